// File: rtl/c4_win_scanner.sv
// Connect4 board keeper: resolves drop rows, stores coins, then walks the four lines
// through the new coin one cell per clock. Optional draw detection: C4_DRAW_DETECT_EN.
module c4_win_scanner #(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       place_valid,
    input  logic [2:0] place_col,
    input  logic       place_player,
    output logic       ready,
    output logic       reject,
    output logic       done,
    output logic [2:0] place_row,
    output logic       win,
    output logic       win_player,
    output logic       draw,
    output logic [5:0] moves,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [3:0]        STEP_LAST = 4'(2 * WIN_LEN - 2);
    localparam logic [3:0]        RUN_WIN   = 4'(WIN_LEN);
    localparam logic [3:0]        H_FULL    = 4'(ROWS);
    localparam logic [3:0]        COLS_U    = 4'(COLS);
    localparam logic [5:0]        CELLS     = 6'(COLS * ROWS);
    localparam logic signed [5:0] K_OFS     = 6'(WIN_LEN - 1);
    localparam logic signed [5:0] COLS_S    = 6'(COLS);
    localparam logic signed [5:0] ROWS_S    = 6'(ROWS);

    logic [2:0] r_state;
    logic [1:0] r_board [8][8];
    logic [3:0] r_height [8];
    logic [2:0] r_col;
    logic [2:0] r_row;
    logic       r_player;
    logic [3:0] r_step;
    logic [1:0] r_dir;
    logic [3:0] r_run;
    logic       r_hit;
    logic       r_reject;
    logic       r_win;
    logic       r_win_player;
    logic       r_draw;
    logic [5:0] r_moves;

    logic signed [5:0] w_k;
    logic signed [5:0] w_col_s;
    logic signed [5:0] w_row_s;
    logic signed [5:0] w_c;
    logic signed [5:0] w_r;
    logic              w_on;
    logic [1:0]        w_cell;
    logic [1:0]        w_code;
    logic              w_match;
    logic [3:0]        w_run_base;
    logic [3:0]        w_run_next;
    logic              w_hit_now;
    logic              w_col_ok;
    logic              w_col_full;
    logic              w_draw_next;

    // Scan cell = new coin + k*(dc,dr); bounds are checked signed so nothing wraps.
    assign w_k     = $signed({2'b00, r_step}) - K_OFS;
    assign w_col_s = $signed({3'b000, r_col});
    assign w_row_s = $signed({3'b000, r_row});

    always_comb begin
        w_c = w_col_s;
        w_r = w_row_s;
        case (r_dir)
            2'd0: w_c = w_col_s + w_k;
            2'd1: w_r = w_row_s + w_k;
            2'd2: begin
                w_c = w_col_s + w_k;
                w_r = w_row_s + w_k;
            end
            default: begin
                w_c = w_col_s + w_k;
                w_r = w_row_s - w_k;
            end
        endcase
    end

    assign w_on       = (w_c >= 6'sd0) && (w_c < COLS_S) && (w_r >= 6'sd0) && (w_r < ROWS_S);
    assign w_cell     = w_on ? r_board[w_c[2:0]][w_r[2:0]] : 2'b00;
    assign w_code     = r_player ? 2'd2 : 2'd1;
    assign w_match    = w_on && (w_cell == w_code);
    assign w_run_base = (r_step == 4'd0) ? 4'd0 : r_run;
    assign w_run_next = w_match ? (w_run_base + 4'd1) : 4'd0;
    assign w_hit_now  = (w_run_next >= RUN_WIN);

    assign w_col_ok   = ({1'b0, place_col} < COLS_U);
    assign w_col_full = (r_height[place_col] >= H_FULL);

`ifdef C4_DRAW_DETECT_EN
    assign w_draw_next = !(r_hit || w_hit_now) && (r_moves == CELLS);
`else
    assign w_draw_next = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_col        <= 3'd0;
            r_row        <= 3'd0;
            r_player     <= 1'b0;
            r_step       <= 4'd0;
            r_dir        <= 2'd0;
            r_run        <= 4'd0;
            r_hit        <= 1'b0;
            r_reject     <= 1'b0;
            r_win        <= 1'b0;
            r_win_player <= 1'b0;
            r_draw       <= 1'b0;
            r_moves      <= 6'd0;
            for (int c = 0; c < 8; c++) begin
                r_height[c] <= 4'd0;
                for (int r = 0; r < 8; r++) r_board[c][r] <= 2'b00;
            end
        end else if (new_game) begin
            r_state      <= S_IDLE;
            r_col        <= 3'd0;
            r_row        <= 3'd0;
            r_player     <= 1'b0;
            r_step       <= 4'd0;
            r_dir        <= 2'd0;
            r_run        <= 4'd0;
            r_hit        <= 1'b0;
            r_reject     <= 1'b0;
            r_win        <= 1'b0;
            r_win_player <= 1'b0;
            r_draw       <= 1'b0;
            r_moves      <= 6'd0;
            for (int c = 0; c < 8; c++) begin
                r_height[c] <= 4'd0;
                for (int r = 0; r < 8; r++) r_board[c][r] <= 2'b00;
            end
        end else begin
            r_reject <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (place_valid) begin
                        if (w_col_ok && !w_col_full) begin
                            r_col    <= place_col;
                            r_player <= place_player;
                            r_row    <= r_height[place_col][2:0];
                            r_state  <= S_WRITE;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_board[r_col][r_row] <= w_code;
                    r_height[r_col]       <= r_height[r_col] + 4'd1;
                    r_moves               <= r_moves + 6'd1;
                    r_step                <= 4'd0;
                    r_dir                 <= 2'd0;
                    r_hit                 <= 1'b0;
                    r_state               <= S_SCAN;
                end
                S_SCAN: begin
                    r_run <= w_run_next;
                    r_hit <= r_hit | w_hit_now;
                    if (r_step == STEP_LAST) begin
                        r_step <= 4'd0;
                        // Results land on the last scan edge so they are visible with done.
                        if (r_dir == 2'd3) begin
                            r_win        <= r_hit | w_hit_now;
                            r_win_player <= r_player;
                            r_draw       <= w_draw_next;
                            r_state      <= S_DONE;
                        end else begin
                            r_dir <= r_dir + 2'd1;
                        end
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                S_DONE: r_state <= (r_win || r_draw) ? S_OVER : S_IDLE;
                S_OVER: r_state <= S_OVER;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready      = (r_state == S_IDLE);
    assign done       = (r_state == S_DONE);
    assign reject     = r_reject;
    assign place_row  = r_row;
    assign win        = r_win;
    assign win_player = r_win_player;
    assign draw       = r_draw;
    assign moves      = r_moves;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_c4_win_scanner.sv
// Bench for c4_win_scanner: table of drops with hand-derived wins, scoreboard of done results,
// plus hand sequences for board fill and a new_game abort in mid-scan.
module tb_c4_win_scanner;

    logic       clk;
    logic       rst;
    logic       new_game;
    logic       place_valid;
    logic [2:0] place_col;
    logic       place_player;
    logic       ready;
    logic       reject;
    logic       done;
    logic [2:0] place_row;
    logic       win;
    logic       win_player;
    logic       draw;
    logic [5:0] moves;
    logic [2:0] dbg_state;

    c4_win_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .place_valid  (place_valid),
        .place_col    (place_col),
        .place_player (place_player),
        .ready        (ready),
        .reject       (reject),
        .done         (done),
        .place_row    (place_row),
        .win          (win),
        .win_player   (win_player),
        .draw         (draw),
        .moves        (moves),
        .dbg_state    (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct packed {
        logic       ng;
        logic [2:0] col;
        logic       pl;
        logic       rej;
        logic       win;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    int          m_height[8];
    int          m_moves;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 8; c++) m_height[c] = 0;
        m_moves = 0;
    endtask

    task automatic add(input logic ng, input logic [2:0] col, input logic pl, input logic rej,
                       input logic w);
        vec_t v;
        v.ng = ng; v.col = col; v.pl = pl; v.rej = rej; v.win = w;
        vecs.push_back(v);
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        check("new_game_clear",
              32'({ready, reject, done, place_row, win, win_player, draw, moves}),
              32'({1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0}));
    endtask

    // Game is over: a request must produce neither reject nor done, and ready stays low.
    task automatic ignored_request();
        logic seen;
        seen = 1'b0;
        place_valid = 1'b1;
        place_col = 3'(($urandom_range(0, 6)));
        place_player = 1'($urandom_range(0, 1));
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            place_valid = 1'b0;
            if (reject || done || ready) seen = 1'b1;
        end
        check("over_ignores_request", 32'(seen), 32'd0);
        check("over_moves_held", 32'(moves), 32'(m_moves));
    endtask

    task automatic drop(input logic [2:0] col, input logic pl, input logic exp_rej,
                        input logic exp_win);
        int          n;
        logic        exp_draw;
        logic [11:0] exp_w;
        check("ready_before_drop", 32'(ready), 32'd1);
        place_valid  = 1'b1;
        place_col    = col;
        place_player = pl;
        @(negedge clk);
        place_valid  = 1'b0;
        if (exp_rej) begin
            check("reject_pulse", 32'(reject), 32'd1);
            check("reject_ready", 32'(ready), 32'd1);
            check("reject_moves", 32'(moves), 32'(m_moves));
            @(negedge clk);
            check("reject_one_cycle", 32'(reject), 32'd0);
        end else begin
`ifdef C4_DRAW_DETECT_EN
            exp_draw = !exp_win && (m_moves + 1 == 7 * 6);
`else
            exp_draw = 1'b0;
`endif
            exp_q.push_back({3'(m_height[col]), exp_win, pl, exp_draw, 6'(m_moves + 1)});
            m_height[col]++;
            m_moves++;
            check("busy_ready_low", 32'(ready), 32'd0);
            check("accept_no_reject", 32'(reject), 32'd0);
            n = 1;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("done_latency", 32'(n), 32'd30);
            exp_w = exp_q.pop_front();
            if (done)
                check("done_outputs", 32'({place_row, win, win_player, draw, moves}), 32'(exp_w));
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("ready_after_done", 32'(ready), 32'(!(exp_win || exp_draw)));
            if (exp_win || exp_draw) ignored_request();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_clear();
        rst = 1'b0;
        new_game = 1'b0;
        place_valid = 1'b0;
        place_col = 3'd0;
        place_player = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({ready, reject, done, place_row, win, win_player, draw, moves}),
              32'({1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0}));
        rst = 1'b1;
        @(negedge clk);

        // vertical p0 in col 3
        add(1, 3, 0, 0, 0); add(0, 3, 0, 0, 0); add(0, 3, 0, 0, 0); add(0, 3, 0, 0, 1);
        // horizontal p0 on row 0, p1 stacked on top
        add(1, 0, 0, 0, 0); add(0, 0, 1, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 1, 0, 0);
        add(0, 2, 0, 0, 0); add(0, 2, 1, 0, 0); add(0, 3, 0, 0, 1);
        // diagonal (0,0)..(3,3) for p1, (1,1) last
        add(1, 0, 1, 0, 0); add(0, 1, 0, 0, 0); add(0, 2, 0, 0, 0); add(0, 2, 0, 0, 0);
        add(0, 2, 1, 0, 0); add(0, 3, 0, 0, 0); add(0, 3, 1, 0, 0); add(0, 3, 0, 0, 0);
        add(0, 3, 1, 0, 0); add(0, 1, 1, 0, 1);
        // anti-diagonal (0,3)..(3,0) for p1, (2,1) last
        add(1, 3, 1, 0, 0); add(0, 2, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0); add(0, 0, 0, 0, 0); add(0, 0, 1, 0, 0); add(0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0); add(0, 2, 1, 0, 1);
        // full column and out-of-range column
        add(1, 6, 0, 0, 0); add(0, 6, 1, 0, 0); add(0, 6, 0, 0, 0); add(0, 6, 1, 0, 0);
        add(0, 6, 0, 0, 0); add(0, 6, 1, 0, 0); add(0, 6, 0, 1, 0); add(0, 7, 1, 1, 0);

        foreach (vecs[i]) begin
            if (vecs[i].ng) pulse_new_game();
            drop(vecs[i].col, vecs[i].pl, vecs[i].rej, vecs[i].win);
        end

        // Whole board in a pattern with runs no longer than two in any direction.
        pulse_new_game();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                drop(3'(c), 1'((c + r / 2) % 2), 1'b0, 1'b0);
`ifdef C4_DRAW_DETECT_EN
        check("full_board_draw", 32'({draw, moves}), 32'({1'b1, 6'd42}));
`else
        check("full_board_no_draw", 32'({draw, moves}), 32'({1'b0, 6'd42}));
        drop(3'($urandom_range(0, 6)), 1'b0, 1'b1, 1'b0);
`endif

        // new_game during the scan of a second coin in col 0
        pulse_new_game();
        drop(3'd0, 1'b0, 1'b0, 1'b0);
        place_valid  = 1'b1;
        place_col    = 3'd0;
        place_player = 1'b1;
        @(negedge clk);
        place_valid  = 1'b0;
        for (int n = 1; n < 10; n++) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        check("abort_clear",
              32'({ready, done, place_row, win, draw, moves}),
              32'({1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 6'd0}));
        begin
            logic seen_done;
            seen_done = 1'b0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (done) seen_done = 1'b1;
            end
            check("abort_no_done", 32'(seen_done), 32'd0);
        end
        drop(3'd0, 1'b1, 1'b0, 1'b0);
        check("abort_board_empty_row", 32'(place_row), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/c4_win_scanner.md
# c4_win_scanner

Board-state keeper and sequential four-in-a-row detector for the Connect4 game. It consumes coin-drop requests (column plus player) from the control logic and resolves each drop's landing row from its own per-column height counters. It stores the coin in a private 7x6 board and then walks the four lines through the new coin, one cell per clock. It returns landing row, win and draw status to the control stage, which uses them to drive memory writes and end-of-game handling.

## Interface
Parameters:
- COLS, 7, board columns (1..8)
- ROWS, 6, board rows (1..8); row 0 is the bottom
- WIN_LEN, 4, run length that wins (2..min(COLS,ROWS))

Ports:
- clk  in  1  system clock (divided game clock)
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- new_game  in  1  synchronous clear of board, heights, flags, counters
- place_valid  in  1  drop request; sampled only while ready=1
- place_col  in  3  target column
- place_player  in  1  0 = player 1, 1 = player 2
- ready  out  1  block idle and game not over
- reject  out  1  one-cycle pulse: request refused (column full or place_col>=COLS)
- done  out  1  one-cycle pulse: drop stored and scan finished
- place_row  out  3  landing row of last accepted drop; held until next accept
- win  out  1  sticky: last scan found a run >= WIN_LEN
- win_player  out  1  player owning the winning run; valid while win=1
- draw  out  1  sticky: board full with no win (see Configuration)
- moves  out  6  count of coins stored this game

## Operation
- State machine IDLE -> WRITE -> SCAN -> DONE -> IDLE; OVER is entered from DONE when win or draw is set.
- IDLE: ready=1. place_valid=1 with a legal column: latch col/player, place_row <= height[col], go to WRITE. With an illegal column: reject=1 next cycle, stay IDLE, no state change.
- WRITE: board[col][row] <= player+1 (2-bit cell, 0 = empty); height[col]++; moves++.
- SCAN: four directions in order: horizontal (dc=+1,dr=0), vertical (0,+1), diagonal (+1,+1), anti-diagonal (+1,-1). Per direction, offset k steps -(WIN_LEN-1)..+(WIN_LEN-1), visiting cell (col+k*dc, row+k*dr).
  - Run counter resets to 0 at each direction start. It increments when the cell equals the current player's code. It resets when the cell differs or lies off-board.
  - Off-board is tested in signed arithmetic, at least 5 bits, before indexing. It never wraps.
  - The run counter reaching WIN_LEN sets a hit flag. The scan always completes all steps.
- DONE: done=1; win <= hit, win_player <= player; draw as in Configuration. Go to OVER if win or draw, else IDLE.
- OVER: ready=0; all requests ignored (no reject). Only new_game or rst leaves OVER.
- new_game has priority over every state and over a same-cycle place_valid. It aborts a scan in progress without a done pulse. It returns to IDLE with all outputs at reset values.

## Timing
- Reset/new_game values: ready=1, reject=0, done=0, place_row=0, win=0, win_player=0, draw=0, moves=0, board empty, heights 0, state IDLE.
- Accept at cycle 0. WRITE at cycle 1. SCAN for 4*(2*WIN_LEN-1) cycles (cycles 2..29 for WIN_LEN=4). done=1 at cycle 30. ready=1 again at cycle 31 if the game is not over.
- reject asserts in cycle 1 after the offending sample, for exactly one cycle. ready stays 1.
- ready=0 from cycle 1 to the done cycle inclusive. place_valid is ignored throughout.
- win/draw/win_player update in the done cycle and are stable by the next edge.

## Configuration
- C4_DRAW_DETECT_EN defined: in DONE, if hit=0 and moves==COLS*ROWS, set draw=1 and go to OVER.
- Not defined: draw is tied to 0. A full board leaves the block in IDLE, and every request returns reject because all columns are full.

## Test plan
- Reset, then drop p0 into col 3 four times (p1 not interleaved) -> place_row 0,1,2,3; win=0 after the first three; on the fourth, done at cycle 30, win=1, win_player=0, ready=0.
- Alternate p0 cols 0,1,2,3 with p1 cols 0,1,2 on top -> win=1, win_player=0 on p0's col-3 drop; a further place_valid is ignored with no reject.
- Build the diagonal (0,0),(1,1),(2,2),(3,3) for p1 with filler coins, placing (1,1) last -> win=1; a similar anti-diagonal set -> win=1.
- Fill col 6 with 6 coins, then place_col=6 -> reject one-cycle pulse, moves stays 6; place_col=7 -> reject.
- Fill the board in a no-win pattern: with C4_DRAW_DETECT_EN, draw=1 and moves=42 at the 42nd done; without the macro, draw=0 and the next request is rejected.
- Assert new_game in SCAN cycle 10 -> no done pulse; next cycle ready=1, moves=0, board empty; col-0 drop then lands at row 0.
